write_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single serial address/data writer among N_REQ requesters. It accepts address/data write requests and grants one requester at a time. For each grant it presents that requester's address/data to the writer and fires a one-cycle start. It then waits for the writer's completion ack, with a watchdog timeout. Completion or error is reported back to the granted requester.

---
 rtl/write_arbiter_if.sv | 33 +++
 rtl/write_arbiter.sv | 122 ++++++++++++
 tb/tb_write_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/write_arbiter_if.sv
// Requester and writer-side signals of the write arbiter, bundled for port hookup.
interface write_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 8
);
    // Requester side
    logic [N_REQ-1:0]    req;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    done;
    logic [N_REQ-1:0]    err;
    logic                busy;

    // Writer side
    logic                wr_start;
    logic [AW-1:0]       wr_address;
    logic [DW-1:0]       wr_data;
    logic                wr_ack;

    // Arbiter view
    modport master (
        input  req, req_addr, req_data, wr_ack,
        output gnt, done, err, busy, wr_start, wr_address, wr_data
    );

    // Requester/writer view
    modport slave (
        output req, req_addr, req_data, wr_ack,
        input  gnt, done, err, busy, wr_start, wr_address, wr_data
    );
endinterface

// File: rtl/write_arbiter.sv
// Round-robin arbiter that shares one serial writer among N_REQ requesters,
// issuing a start pulse per grant and waiting for ack under a watchdog.
module write_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic            clk,
    input  logic            rst,
    write_arbiter_if.master bus
);
    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   gidx_q;
    logic [TW-1:0]   timer_q;

    logic            pick_valid_c;
    logic [IW-1:0]   pick_idx_c;
    logic [IW-1:0]   cand_c;
    logic [N_REQ-1:0] pick_onehot_c;
    logic [AW-1:0]   pick_addr_c;
    logic [DW-1:0]   pick_data_c;

    // First active request searching from last+1 with wrap-around
    always_comb begin
        pick_valid_c = 1'b0;
        pick_idx_c   = '0;
        cand_c       = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand_c = IW'((32'(last_q) + 32'(k) + 32'd1) % N_REQ);
            if (!pick_valid_c && bus.req[cand_c]) begin
                pick_valid_c = 1'b1;
                pick_idx_c   = cand_c;
            end
        end
    end

    // One-hot grant and address/data slice of the selected requester
    always_comb begin
        pick_onehot_c             = '0;
        pick_onehot_c[pick_idx_c] = 1'b1;
        pick_addr_c               = '0;
        pick_data_c               = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_idx_c == IW'(i)) begin
                pick_addr_c = bus.req_addr[i*AW +: AW];
                pick_data_c = bus.req_data[i*DW +: DW];
            end
        end
    end

    // Sequencer: grant, start pulse, ack/timeout wait, release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            last_q         <= IW'(N_REQ - 1);
            gidx_q         <= '0;
            timer_q        <= '0;
            bus.gnt        <= '0;
            bus.done       <= '0;
            bus.err        <= '0;
            bus.busy       <= 1'b0;
            bus.wr_start   <= 1'b0;
            bus.wr_address <= '0;
            bus.wr_data    <= '0;
        end else begin
            bus.wr_start <= 1'b0;
            bus.done     <= '0;
            bus.err      <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_valid_c) begin
                        bus.gnt        <= pick_onehot_c;
                        bus.wr_address <= pick_addr_c;
                        bus.wr_data    <= pick_data_c;
                        gidx_q         <= pick_idx_c;
                        bus.busy       <= 1'b1;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.wr_start <= 1'b1;
                    timer_q      <= '0;
                    state_q      <= WAIT;
                end
                WAIT: begin
                    // ack takes precedence over a coincident timeout
                    if (bus.wr_ack) begin
                        bus.done <= bus.gnt;
                        last_q   <= gidx_q;
                        state_q  <= RELEASE;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        bus.err  <= bus.gnt;
                        last_q   <= gidx_q;
                        state_q  <= RELEASE;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RELEASE: begin
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_write_arbiter.sv
// Scoreboard bench for write_arbiter: a round-robin service-order model predicts
// each transaction; a monitor checks start/grant/payload and completion timing.
module tb_write_arbiter;
    localparam int N_REQ   = 4;
    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int TIMEOUT = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ack_w = 1'b0;
    logic ack_x = 1'b0;

    always #5 clk = ~clk;

    write_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

    write_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.wr_ack = ack_w | ack_x;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            dly;   // ack delay after wr_start in cycles, -1 = never
    } item_t;

    typedef struct {
        int            idx;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            is_err;
        int            dly;
    } exp_t;

    item_t items [N_REQ][$];
    exp_t  sb_q [$];
    int    dly_q [$];

    int    checks = 0;
    int    errors = 0;
    int    model_last = N_REQ - 1;
    int    gen = 0;
    bit    have_cur = 1'b0;
    exp_t  cur;
    int    cyc = 0;
    int    start_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_item(input int r, input int a, input int d, input int dly);
        item_t it;
        it.a   = AW'(a);
        it.d   = DW'(d);
        it.dly = dly;
        items[r].push_back(it);
    endtask

    // Predict service order from pending counts and the round-robin pointer, then raise requests
    task automatic start_batch();
        int   rem [N_REQ];
        int   used [N_REQ];
        int   total;
        int   j;
        exp_t e;
        total = 0;
        j = 0;
        for (int i = 0; i < N_REQ; i++) begin
            rem[i]  = items[i].size();
            used[i] = 0;
            total  += rem[i];
        end
        while (total > 0) begin
            for (int k = 1; k <= N_REQ; k++) begin
                j = (model_last + k) % N_REQ;
                if (rem[j] > 0) break;
            end
            e.idx    = j;
            e.a      = items[j][used[j]].a;
            e.d      = items[j][used[j]].d;
            e.dly    = items[j][used[j]].dly;
            e.is_err = (e.dly < 0) || (e.dly >= TIMEOUT);
            sb_q.push_back(e);
            dly_q.push_back(e.dly);
            rem[j]--;
            used[j]++;
            total--;
            model_last = j;
        end
        for (int i = 0; i < N_REQ; i++) begin
            bus.req[i] = (items[i].size() > 0);
            if (items[i].size() > 0) begin
                bus.req_addr[i*AW +: AW] = items[i][0].a;
                bus.req_data[i*DW +: DW] = items[i][0].d;
            end
        end
    endtask

    // Requesters retire items on done/err and drop req after their last one
    task automatic wait_batch(input string tag);
        int n;
        bit fin;
        bit any;
        n = 0;
        fin = 1'b0;
        while (!fin && n < 3000) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.done[i] || bus.err[i]) begin
                    if (items[i].size() > 0) void'(items[i].pop_front());
                    if (items[i].size() == 0) begin
                        bus.req[i] = 1'b0;
                    end else begin
                        bus.req_addr[i*AW +: AW] = items[i][0].a;
                        bus.req_data[i*DW +: DW] = items[i][0].d;
                    end
                end
            end
            any = 1'b0;
            for (int i = 0; i < N_REQ; i++) any |= (items[i].size() > 0);
            if (!any) begin
                @(negedge clk);
                chk({tag, "_busy_idle"}, 64'(bus.busy), 64'(0));
                chk({tag, "_gnt_idle"}, 64'(bus.gnt), 64'(0));
                chk({tag, "_sb_drained"}, 64'(sb_q.size()), 64'(0));
                chk({tag, "_no_open_txn"}, 64'(have_cur), 64'(0));
                fin = 1'b1;
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: batch still open after %0d cycles", tag, n);
        end
    endtask

    // Writer model: ack a programmed number of cycles after each wr_start
    initial begin : writer
        int d;
        int g;
        forever begin
            @(negedge clk);
            if (rst && bus.wr_start) begin
                d = (dly_q.size() > 0) ? dly_q.pop_front() : -1;
                g = gen;
                if (d > 0) begin
                    repeat (d) @(negedge clk);
                    if (g == gen && rst) ack_w = 1'b1;
                    @(negedge clk);
                    ack_w = 1'b0;
                end
            end
        end
    end

    // Monitor: pop expectation on wr_start, close it on done/err
    initial begin : monitor
        int lat_exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if ($countones(bus.gnt) > 1) begin
                    checks++;
                    errors++;
                    $display("FAIL gnt_onehot: got %b expected at most one bit", bus.gnt);
                end
                if (bus.wr_start) begin
                    if (have_cur) begin
                        checks++;
                        errors++;
                        $display("FAIL start_overlap: got wr_start expected none while txn open");
                    end
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: got wr_start gnt=%b expected no transaction", bus.gnt);
                    end else begin
                        cur       = sb_q.pop_front();
                        have_cur  = 1'b1;
                        start_cyc = cyc;
                        chk("start_gnt", 64'(bus.gnt), 64'(1) << cur.idx);
                        chk("start_addr", 64'(bus.wr_address), 64'(cur.a));
                        chk("start_data", 64'(bus.wr_data), 64'(cur.d));
                    end
                end
                if ((|bus.done) || (|bus.err)) begin
                    if (!have_cur) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: got done=%b err=%b expected none", bus.done, bus.err);
                    end else begin
                        lat_exp = cur.is_err ? TIMEOUT : cur.dly + 1;
                        chk("done_vec", 64'(bus.done), cur.is_err ? 64'(0) : (64'(1) << cur.idx));
                        chk("err_vec", 64'(bus.err), cur.is_err ? (64'(1) << cur.idx) : 64'(0));
                        chk("complete_latency", 64'(cyc - start_cyc), 64'(lat_exp));
                        chk("hold_addr", 64'(bus.wr_address), 64'(cur.a));
                        chk("hold_data", 64'(bus.wr_data), 64'(cur.d));
                        chk("hold_gnt", 64'(bus.gnt), 64'(1) << cur.idx);
                        have_cur = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int r;
        int n;
        int tot;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", 64'(bus.gnt), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_err", 64'(bus.err), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_wr_start", 64'(bus.wr_start), 64'(0));
        chk("rst_addr", 64'(bus.wr_address), 64'(0));
        chk("rst_data", 64'(bus.wr_data), 64'(0));
        #2 rst = 1'b1;

        // All four requesting, requester 0 twice: order 0,1,2,3,0
        @(negedge clk);
        add_item(0, 8'h10, 8'hA0, 20);
        add_item(0, 8'h14, 8'hA4, 22);
        add_item(1, 8'h11, 8'hA1, 21);
        add_item(2, 8'h12, 8'hA2, 18);
        add_item(3, 8'h13, 8'hA3, 25);
        start_batch();
        wait_batch("rr4");

        // Single request with directed latency checks
        add_item(0, 8'h3A, 8'hC5, 19);
        start_batch();
        @(negedge clk);
        chk("single_gnt_1edge", 64'(bus.gnt), 64'(4'b0001));
        chk("single_busy", 64'(bus.busy), 64'(1));
        chk("single_no_start_yet", 64'(bus.wr_start), 64'(0));
        @(negedge clk);
        chk("single_start_2edge", 64'(bus.wr_start), 64'(1));
        wait_batch("single");

        // Serve 1, then 1 and 3 together: 3 goes first
        add_item(1, 8'h21, 8'h51, 15);
        start_batch();
        wait_batch("serve1");
        add_item(1, 8'h22, 8'h52, 14);
        add_item(3, 8'h23, 8'h53, 17);
        start_batch();
        @(negedge clk);
        chk("prio_3_before_1", 64'(bus.gnt), 64'(4'b1000));
        wait_batch("prio31");

        // Writer never acks: timeout error, then next requester is served
        add_item(0, 8'h30, 8'h60, -1);
        add_item(1, 8'h31, 8'h61, 10);
        start_batch();
        wait_batch("timeout");

        // Ack on the last timer cycle wins; one cycle later is a timeout
        add_item(2, 8'h42, 8'h72, 31);
        add_item(3, 8'h43, 8'h73, 32);
        start_batch();
        wait_batch("boundary");

        // Randomized batches
        for (int b = 0; b < 6; b++) begin
            tot = 0;
            for (int i = 0; i < N_REQ; i++) begin
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) begin
                    r = $urandom_range(0, 9);
                    if (r == 0) add_item(i, $urandom, $urandom, -1);
                    else if (r == 1) add_item(i, $urandom, $urandom, $urandom_range(31, 33));
                    else add_item(i, $urandom, $urandom, $urandom_range(1, 28));
                    tot++;
                end
            end
            if (tot == 0) add_item(0, $urandom, $urandom, 9);
            start_batch();
            wait_batch("rand");
        end

        // Asynchronous reset in the middle of WAIT
        add_item(0, 8'h55, 8'hAA, -1);
        start_batch();
        repeat (6) @(negedge clk);
        chk("pre_reset_busy", 64'(bus.busy), 64'(1));
        #3 rst = 1'b0;
        gen++;
        #1;
        chk("arst_gnt", 64'(bus.gnt), 64'(0));
        chk("arst_done_err", 64'({bus.done, bus.err}), 64'(0));
        chk("arst_busy", 64'(bus.busy), 64'(0));
        chk("arst_wr_start", 64'(bus.wr_start), 64'(0));
        chk("arst_addr_data", 64'({bus.wr_address, bus.wr_data}), 64'(0));
        sb_q.delete();
        dly_q.delete();
        for (int i = 0; i < N_REQ; i++) items[i].delete();
        bus.req    = '0;
        have_cur   = 1'b0;
        model_last = N_REQ - 1;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;

        // Stray ack while idle has no effect
        @(negedge clk);
        ack_x = 1'b1;
        @(negedge clk);
        ack_x = 1'b0;
        chk("idle_ack_busy", 64'(bus.busy), 64'(0));
        chk("idle_ack_done", 64'(bus.done), 64'(0));
        @(negedge clk);
        chk("idle_ack_busy2", 64'(bus.busy), 64'(0));

        // After reset requester 1 wins over 3; ack during ISSUE is ignored
        add_item(1, 8'h61, 8'h91, 12);
        add_item(3, 8'h63, 8'h93, 16);
        start_batch();
        @(negedge clk);
        chk("post_reset_gnt", 64'(bus.gnt), 64'(4'b0010));
        ack_x = 1'b1;
        @(negedge clk);
        ack_x = 1'b0;
        chk("issue_ack_start", 64'(bus.wr_start), 64'(1));
        chk("issue_ack_no_done", 64'(bus.done), 64'(0));
        wait_batch("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
